// File: rtl/muldiv_sched.sv
// Multiply/divide issue scheduler: launches EX mul/div ops to external engines, stalls EX and writes {HI,LO} once.
// Optional build macro MULDIV_DIV0_FAST_EN: divide-by-zero completes locally without starting the divider.
module muldiv_sched #(
    parameter int unsigned MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [31:0] op_src1,
    input  logic [31:0] op_src2,
    input  logic        annul,
    input  logic        hold_in,
    output logic        stallreq,
    output logic        busy,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opdata1,
    output logic [31:0] div_opdata2,
    output logic        div_annul,
    input  logic [63:0] div_result,
    input  logic        div_ready
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MUL_WAIT = 2'd1;
    localparam logic [1:0] ST_DIV_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b10;

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 32'd1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_type_q, op_type_d;
    logic [31:0] src1_q, src1_d;
    logic [31:0] src2_q, src2_d;
    logic [63:0] result_q, result_d;
    logic        first_q, first_d;

    // Next-state, operand capture and result capture
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_type_d = op_type_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        result_d  = result_q;
        first_d   = 1'b0;
        if (annul) begin
            // A flush abandons whatever is in flight, including a same-cycle div_ready
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        op_type_d = op_type;
                        src1_d    = op_src1;
                        src2_d    = op_src2;
                        if (op_type[1] == 1'b0) begin
                            state_d = ST_MUL_WAIT;
                            cnt_d   = CNT_INIT;
                        end else begin
`ifdef MULDIV_DIV0_FAST_EN
                            if (op_src2 == 32'd0) begin
                                state_d  = ST_DONE;
                                result_d = {op_src1, 32'hFFFF_FFFF};
                                first_d  = 1'b1;
                            end else begin
                                state_d = ST_DIV_WAIT;
                            end
`else
                            state_d = ST_DIV_WAIT;
`endif
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_MUL_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        result_d = mul_result;
                        state_d  = ST_DONE;
                        first_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_ready) begin
                        result_d = div_result;
                        state_d  = ST_DONE;
                        first_d  = 1'b1;
                    end else begin
                        state_d = ST_DIV_WAIT;
                    end
                end
                ST_DONE: begin
                    // A stalled pipeline keeps the finished op parked here so it is not relaunched
                    if (hold_in) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            op_type_q <= 2'b00;
            src1_q    <= 32'd0;
            src2_q    <= 32'd0;
            result_q  <= 64'd0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_type_q <= op_type_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            result_q  <= result_d;
            first_q   <= first_d;
        end
    end

    // Outputs; resetn gating keeps the input-driven terms quiet while in reset
    always_comb begin
        stallreq    = resetn & op_valid & ~annul & (state_q != ST_DONE);
        busy        = (state_q != ST_IDLE);
        hilo_we     = first_q & (state_q == ST_DONE) & ~annul;
        hilo_wdata  = result_q;
        mul_signed  = resetn & (op_type_q == OP_MULT);
        mul_ina     = src1_q;
        mul_inb     = src2_q;
        div_start   = (state_q == ST_DIV_WAIT);
        div_signed  = (op_type_q == OP_DIV);
        div_opdata1 = src1_q;
        div_opdata2 = src2_q;
        div_annul   = annul & (state_q == ST_DIV_WAIT);
    end

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched with behavioural multiplier/divider models and a result scoreboard.
module tb_muldiv_sched;

    localparam int MUL_LAT = 2;

    logic        clk;
    logic        resetn;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] op_src1;
    logic [31:0] op_src2;
    logic        annul;
    logic        hold_in;
    logic        stallreq;
    logic        busy;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opdata1;
    logic [31:0] div_opdata2;
    logic        div_annul;
    logic [63:0] div_result;
    logic        div_ready;

    muldiv_sched #(.MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type),
        .op_src1(op_src1), .op_src2(op_src2), .annul(annul), .hold_in(hold_in),
        .stallreq(stallreq), .busy(busy), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
        .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb), .mul_result(mul_result),
        .div_start(div_start), .div_signed(div_signed), .div_opdata1(div_opdata1),
        .div_opdata2(div_opdata2), .div_annul(div_annul), .div_result(div_result),
        .div_ready(div_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural engines
    always_comb begin
        if (mul_signed)
            mul_result = $signed({{32{mul_ina[31]}}, mul_ina}) * $signed({{32{mul_inb[31]}}, mul_inb});
        else
            mul_result = {32'd0, mul_ina} * {32'd0, mul_inb};
    end

    logic signed [31:0] sa, sb, sq, sr;
    int div_lat = 2;
    int dcnt = 0;

    always_comb begin
        sa = $signed(div_opdata1);
        sb = $signed(div_opdata2);
        sq = 32'sd0;
        sr = 32'sd0;
        div_result = 64'd0;
        if (div_opdata2 == 32'd0) begin
            div_result = {div_opdata1, 32'hFFFF_FFFF};
        end else if (div_signed) begin
            sq = sa / sb;
            sr = sa % sb;
            div_result = {sr, sq};
        end else begin
            div_result = {div_opdata1 % div_opdata2, div_opdata1 / div_opdata2};
        end
    end

    always_comb div_ready = div_start && (dcnt == div_lat - 1);

    always @(posedge clk) dcnt <= div_start ? dcnt + 1 : 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic        sgn;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[10];
    logic [63:0] sb_q[$];

    int tests_run = 0;
    int tests_failed = 0;
    int we_count = 0;
    int div_annul_cnt = 0;
    logic seen_div_start = 1'b0;
    logic last_stall, last_busy, last_mul_signed, last_div_signed, last_div_annul, last_div_ready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Sample at the falling edge, then return 1ns after the next rising edge for input updates
    task automatic tick();
        #4;
        if (hilo_we) begin
            we_count++;
            if (sb_q.size() == 0) check("hilo_we_unexpected", {63'd0, hilo_we}, 64'd0);
            else check("hilo_wdata", hilo_wdata, sb_q.pop_front());
        end
        last_stall      = stallreq;
        last_busy       = busy;
        last_mul_signed = mul_signed;
        last_div_signed = div_signed;
        last_div_annul  = div_annul;
        last_div_ready  = div_ready;
        if (div_annul) div_annul_cnt++;
        if (div_start) seen_div_start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int stalls;
        int we0;
        logic sgn;
        op_valid = 1'b1;
        op_type  = v.op;
        op_src1  = v.a;
        op_src2  = v.b;
        div_lat  = v.lat;
        sb_q.push_back(v.exp);
        we0 = we_count;
        n = 0;
        stalls = 0;
        sgn = 1'b0;
        do begin
            tick();
            n++;
            if (last_stall) stalls++;
            if (n == 2) sgn = v.op[1] ? last_div_signed : last_mul_signed;
        end while (last_stall && n < 200);
        op_valid = 1'b0;
        tick();
        check($sformatf("vec%0d_stall_cycles", idx), 64'(stalls), 64'((v.op[1] ? v.lat : MUL_LAT) + 1));
        check($sformatf("vec%0d_sign", idx), {63'd0, sgn}, {63'd0, v.sgn});
        check($sformatf("vec%0d_we_count", idx), 64'(we_count - we0), 64'd1);
    endtask

    initial begin
        int we0;
        int n;
        int stalls;
        vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 0,  1'b0, 64'h0000_0001_FFFF_FFFE};
        vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0,  1'b1, 64'hFFFF_FFFF_FFFF_FFF1};
        vecs[2] = '{2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0,  1'b1, 64'h3FFF_FFFF_0000_0001};
        vecs[3] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  1'b1, 64'h0000_0000_0000_0001};
        vecs[4] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,  1'b0, 64'hFFFF_FFFE_0000_0001};
        vecs[5] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 34, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[6] = '{2'b11, 32'd100,       32'd7,         5,  1'b0, 64'h0000_0002_0000_000E};
        vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 2,  1'b0, 64'h0000_0001_7FFF_FFFF};
        vecs[8] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1,  1'b1, 64'h0000_0001_FFFF_FFFD};
        vecs[9] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 3,  1'b1, 64'h0000_0000_C000_0000};

        resetn = 1'b0; op_valid = 1'b1; op_type = 2'b00; op_src1 = 32'h55; op_src2 = 32'h66;
        annul = 1'b0; hold_in = 1'b0;
        #12;
        check("reset_ctrl", {58'd0, stallreq, busy, hilo_we, div_start, div_annul, mul_signed}, 64'd0);
        check("reset_data", hilo_wdata | {mul_ina, mul_inb} | {div_opdata1, div_opdata2}, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        op_valid = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // op_valid dropping mid-multiply does not cancel it
        we0 = we_count;
        op_valid = 1'b1; op_type = 2'b00; op_src1 = 32'd6; op_src2 = 32'd7;
        sb_q.push_back(64'd42);
        tick();
        op_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("opvalid_drop_we", 64'(we_count - we0), 64'd1);
        check("opvalid_drop_idle", {63'd0, last_busy}, 64'd0);

        // Completion parked under hold_in
        we0 = we_count;
        hold_in = 1'b1;
        op_valid = 1'b1; op_type = 2'b00; op_src1 = 32'hFFFF_FFFE; op_src2 = 32'd3;
        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
        n = 0;
        do begin tick(); n++; end while (last_stall && n < 50);
        tick();
        tick();
        check("hold_stays_done", {62'd0, last_busy, last_stall}, 64'd2);
        hold_in = 1'b0;
        tick();
        op_valid = 1'b0;
        tick();
        check("hold_we_once", 64'(we_count - we0), 64'd1);
        check("hold_release_idle", {63'd0, last_busy}, 64'd0);

        // Flush on the fifth divider cycle
        we0 = we_count;
        div_annul_cnt = 0;
        div_lat = 40;
        op_valid = 1'b1; op_type = 2'b11; op_src1 = 32'd100; op_src2 = 32'd3;
        for (int i = 0; i < 5; i++) tick();
        annul = 1'b1;
        tick();
        check("annul_div_annul", {63'd0, last_div_annul}, 64'd1);
        check("annul_stallreq", {63'd0, last_stall}, 64'd0);
        annul = 1'b0;
        op_valid = 1'b0;
        tick();
        check("annul_idle", {62'd0, last_busy, last_div_annul}, 64'd0);
        check("annul_pulse_count", 64'(div_annul_cnt), 64'd1);
        check("annul_no_we", 64'(we_count - we0), 64'd0);

        // Flush coinciding with div_ready discards the result
        we0 = we_count;
        div_lat = 3;
        op_valid = 1'b1; op_type = 2'b10; op_src1 = 32'd50; op_src2 = 32'd5;
        for (int i = 0; i < 3; i++) tick();
        annul = 1'b1;
        tick();
        check("annul_ready_overlap", {63'd0, last_div_ready}, 64'd1);
        annul = 1'b0;
        op_valid = 1'b0;
        tick();
        tick();
        check("annul_ready_no_we", 64'(we_count - we0), 64'd0);
        check("annul_ready_idle", {63'd0, last_busy}, 64'd0);

        // Divide by zero
        we0 = we_count;
        seen_div_start = 1'b0;
        div_lat = 4;
        op_valid = 1'b1; op_type = 2'b10; op_src1 = 32'h0000_1234; op_src2 = 32'd0;
        sb_q.push_back(64'h0000_1234_FFFF_FFFF);
        n = 0;
        stalls = 0;
        do begin tick(); n++; if (last_stall) stalls++; end while (last_stall && n < 50);
        op_valid = 1'b0;
        tick();
        check("div0_we", 64'(we_count - we0), 64'd1);
`ifdef MULDIV_DIV0_FAST_EN
        check("div0_stalls", 64'(stalls), 64'd1);
        check("div0_div_start", {63'd0, seen_div_start}, 64'd0);
`else
        check("div0_stalls", 64'(stalls), 64'd5);
        check("div0_div_start", {63'd0, seen_div_start}, 64'd1);
`endif

        // Asynchronous reset in the middle of a multiply
        we0 = we_count;
        op_valid = 1'b1; op_type = 2'b00; op_src1 = 32'd3; op_src2 = 32'd3;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_ctrl", {58'd0, stallreq, busy, hilo_we, div_start, div_annul, mul_signed}, 64'd0);
        check("rst_mid_data", hilo_wdata | {mul_ina, mul_inb} | {div_opdata1, div_opdata2}, 64'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        op_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rst_mid_no_we", 64'(we_count - we0), 64'd0);
        check("rst_mid_idle", {63'd0, last_busy}, 64'd0);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
